// File: rtl/soc_evt_pkg.sv
// ---------------------------------------------------------------------------
// soc_evt_pkg
//
// Shared definitions for the SoC-side peripheral event sender and the
// round-robin pointer arbiter it uses.
//
// Contents:
//   EVNT_WIDTH_DEFAULT : default event ID width. The cluster-side event
//                        FIFO must be built with the same width.
//   EVT_NB_DEFAULT     : default number of SoC peripheral event sources.
//   evt_id_t           : event ID type at the default width.
//   IDX_W              : source index width for the default source count.
//   idx_width()        : index width for an arbitrary source count. It never
//                        returns less than 1, so a vector of one source still
//                        gets a legal index.
// ---------------------------------------------------------------------------
package soc_evt_pkg;

  localparam int EVNT_WIDTH_DEFAULT = 8;
  localparam int EVT_NB_DEFAULT     = 32;

  typedef logic [EVNT_WIDTH_DEFAULT-1:0] evt_id_t;

  // Index width needed to address every source in a vector of n sources.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(EVT_NB_DEFAULT);

endpackage

// File: rtl/rr_arbiter_pointer.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pointer
//
// Purely combinational round-robin search with wrap-around. The search
// starts at (last_ptr + 1) mod N, wraps past index N-1 back to 0, and the
// first asserted request it reaches wins. The block holds no state: the
// caller stores the pointer and updates it when a grant is actually taken.
// That lets other dispatch-style blocks reuse the same search.
//
// Parameters:
//   N      : number of requesters.
//   IDX_W  : width of the pointer and grant index.
//
// Ports:
//   req       in  N      request vector.
//   last_ptr  in  IDX_W  index granted most recently.
//   gnt_valid out 1      at least one request is asserted.
//   gnt_idx   out IDX_W  index of the winning request. It is 0 when
//                        gnt_valid is 0.
// ---------------------------------------------------------------------------
module rr_arbiter_pointer
  import soc_evt_pkg::*;
#(
  parameter int N     = EVT_NB_DEFAULT,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // The wrap-around search runs in two ascending passes, so no modulo is
  // needed. The first pass covers indices above the pointer. The second
  // pass covers indices up to and including the pointer. The second pass
  // only takes a request when the first pass found nothing, so the first
  // hit in wrapped order always wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid && req[i] && (IDX_W'(i) > last_ptr)) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid && req[i] && (IDX_W'(i) <= last_ptr)) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/soc_evt_sender.sv
// ---------------------------------------------------------------------------
// soc_evt_sender
//
// SoC-side transmitter that feeds the cluster's peripheral event FIFO.
// Single-cycle event pulses from NB_EVT peripherals are stored as one
// pending bit per source. Pending sources are arbitrated round-robin, and
// one event ID (ID_BASE + source index) goes out per valid/ready handshake.
// A pulse that arrives while its source is still pending is dropped, and
// the drop is recorded in a sticky per-source lost flag.
//
// Parameters:
//   NB_EVT     : number of event sources (2..256).
//   EVNT_WIDTH : event ID width. Must match the cluster-side receiver.
//   ID_BASE    : ID sent for source 0.
//
// Ports:
//   clk_i        in  1           clock.
//   rst_i        in  1           synchronous active-high reset.
//   evt_i        in  NB_EVT      event pulses. Each high cycle is one event.
//   evt_mask_i   in  NB_EVT      1 = source enabled.
//   evt_valid_o  out 1           event ID available to the cluster.
//   evt_ready_i  in  1           cluster FIFO not full.
//   evt_data_o   out EVNT_WIDTH  event ID.
//   lost_o       out NB_EVT      sticky per-source lost-event flags.
//   lost_clr_i   in  NB_EVT      clears the matching lost_o bits.
//   busy_o       out 1           events pending or the output slot is full.
// ---------------------------------------------------------------------------
module soc_evt_sender
  import soc_evt_pkg::*;
#(
  parameter int NB_EVT     = EVT_NB_DEFAULT,
  parameter int EVNT_WIDTH = EVNT_WIDTH_DEFAULT,
  parameter int ID_BASE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_EVT-1:0]     evt_i,
  input  logic [NB_EVT-1:0]     evt_mask_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  output logic [NB_EVT-1:0]     lost_o,
  input  logic [NB_EVT-1:0]     lost_clr_i,
  output logic                  busy_o
);

  localparam int SRC_IDX_W = idx_width(NB_EVT);
  localparam logic [EVNT_WIDTH-1:0] ID_BASE_V = EVNT_WIDTH'(ID_BASE);
  localparam logic [SRC_IDX_W-1:0]  PTR_RESET = SRC_IDX_W'(NB_EVT - 1);

  // Elaboration-time guards. Every source ID must fit in the event ID
  // width, and the source count must stay in the supported range.
  if ((ID_BASE + NB_EVT) > (1 << EVNT_WIDTH)) begin : g_bad_id_range
    $error("soc_evt_sender: ID_BASE + NB_EVT exceeds the event ID range");
  end
  if ((NB_EVT < 2) || (NB_EVT > 256)) begin : g_bad_nb_evt
    $error("soc_evt_sender: NB_EVT must be within 2..256");
  end

  logic [NB_EVT-1:0]     pending_q;
  logic [NB_EVT-1:0]     lost_q;
  logic [SRC_IDX_W-1:0]  last_grant_q;
  logic                  busy_q;

  logic [NB_EVT-1:0]     capture;
  logic [NB_EVT-1:0]     arb_req;
  logic                  gnt_valid;
  logic [SRC_IDX_W-1:0]  gnt_idx;
  logic                  slot_free;
  logic                  grant_fire;
  logic [NB_EVT-1:0]     grant_vec;
  logic [NB_EVT-1:0]     lost_set;
  logic [NB_EVT-1:0]     pending_next;
  logic [NB_EVT-1:0]     lost_next;
  logic                  valid_next;
  logic                  busy_next;
  logic [EVNT_WIDTH-1:0] grant_id;

  // Masked pulses are discarded right here, so they can never become
  // pending and can never count as lost. A source that is already pending
  // and gets masked later keeps its pending bit. It is only hidden from
  // the arbiter until it is unmasked again.
  assign capture = evt_i & evt_mask_i;
  assign arb_req = pending_q & evt_mask_i;

  rr_arbiter_pointer #(
    .N     (NB_EVT),
    .IDX_W (SRC_IDX_W)
  ) u_arb (
    .req       (arb_req),
    .last_ptr  (last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // The single output register can take a new ID when it is empty or when
  // its current ID is being accepted this cycle.
  assign slot_free  = !evt_valid_o || evt_ready_i;
  assign grant_fire = slot_free && gnt_valid;
  assign grant_id   = ID_BASE_V + EVNT_WIDTH'(gnt_idx);

  // One-hot copy of the grant that is actually taken this cycle.
  always_comb begin
    grant_vec = '0;
    if (grant_fire) begin
      grant_vec[gnt_idx] = 1'b1;
    end
  end

  // A pulse is lost only when its source stays pending this cycle.
  // Clearing the granted bit before OR-ing in the new captures means a
  // pulse on the source that is being granted becomes a fresh pending
  // event. A new loss wins over a clear request on the same bit.
  assign lost_set     = capture & pending_q & ~grant_vec;
  assign pending_next = (pending_q & ~grant_vec) | capture;
  assign lost_next    = (lost_q & ~lost_clr_i) | lost_set;
  assign valid_next   = slot_free ? gnt_valid : evt_valid_o;

  // busy is computed from next-state values and registered, so the output
  // is a flop and cannot glitch. It drops only once the slot is empty and
  // nothing is pending.
  assign busy_next = (|pending_next) || valid_next;

  // All state lives here. The ID register and the round-robin pointer only
  // move when a grant is taken. While the cluster stalls, the held ID stays
  // untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q    <= '0;
      lost_q       <= '0;
      evt_valid_o  <= 1'b0;
      evt_data_o   <= '0;
      last_grant_q <= PTR_RESET;
      busy_q       <= 1'b0;
    end else begin
      pending_q   <= pending_next;
      lost_q      <= lost_next;
      evt_valid_o <= valid_next;
      busy_q      <= busy_next;
      if (grant_fire) begin
        evt_data_o   <= grant_id;
        last_grant_q <= gnt_idx;
      end
    end
  end

  assign lost_o = lost_q;
  assign busy_o = busy_q;

endmodule

// File: doc/soc_evt_sender.md
Name: soc_evt_sender

Overview:
- SoC-side transmitter feeding the cluster's peripheral-event FIFO input, which uses a valid/ready/data port with EVNT_WIDTH-bit IDs.
- Collects single-cycle event pulses from NB_EVT SoC peripherals and holds one pending bit per source.
- Arbitrates pending sources round-robin and sends one event ID per handshake.
- Flags events lost because their source was already pending.

Parameters:
- NB_EVT, 32, number of peripheral event sources (2..256).
- EVNT_WIDTH, 8, event ID width; must match the cluster-side receiver.
- ID_BASE, 0, ID sent for source 0; source i sends ID_BASE+i. Elaboration check: ID_BASE+NB_EVT <= 2**EVNT_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- evt_i  in  NB_EVT  event pulses; each high cycle is one event.
- evt_mask_i  in  NB_EVT  1 = source enabled.
- evt_valid_o  out  1  event available to the cluster.
- evt_ready_i  in  1  cluster FIFO not full.
- evt_data_o  out  EVNT_WIDTH  event ID.
- lost_o  out  NB_EVT  sticky per-source lost-event flags.
- lost_clr_i  in  NB_EVT  clears the matching lost_o bits.
- busy_o  out  1  any pending bit set, or evt_valid_o high.

Behaviour:
- Reset, sampled at a clock edge with rst_i high: pending, lost_o, evt_valid_o all 0; evt_data_o 0; last_grant = NB_EVT-1, so the first search starts at index 0. Reset mid-transfer drops the held event without a handshake; the cluster must be reset together with this block.
- Capture: if evt_i[i] & evt_mask_i[i], pending[i] is set at the next edge.
- Masked pulses are discarded and never counted as lost. A source already pending that is masked afterwards keeps its pending bit but is skipped by arbitration until unmasked.
- Output slot is one register (evt_valid_o, evt_data_o).
  - The slot is free when evt_valid_o=0 or (evt_valid_o & evt_ready_i).
- Arbitration is combinational over pending & evt_mask_i.
  - Search starts at index (last_grant+1) mod NB_EVT and wraps; the first hit wins.
  - If the slot is free and a winner w exists, at the edge: evt_valid_o<=1, evt_data_o<=ID_BASE+w, pending[w] cleared, last_grant<=w.
  - If the slot is free and no winner exists, evt_valid_o<=0.
- Latency: pulse in cycle N gives pending in N+1 and evt_valid_o in N+2 when the slot is free and there is no contention.
- Throughput: one event per cycle while evt_ready_i=1.
- Handshake:
  - While evt_valid_o=1 & evt_ready_i=0, evt_data_o holds stable and valid stays high. No retraction, no change.
  - evt_ready_i is ignored when evt_valid_o=0.
- Simultaneous events:
  - New pulse on source w in the same cycle w is granted: pending[w] stays 1 (new event captured, not lost).
  - Pulse on source i with pending[i]=1 and i not granted that cycle: lost_o[i] set; the event is dropped.
  - lost_clr_i[i] and a new loss on i in the same cycle: set wins.
- Multiple simultaneous pulses on different sources are all captured.
- busy_o is registered-state derived and glitch-free; it goes 0 only once the slot is empty and nothing is pending.

Decomposition:
- Package soc_evt_pkg:
  - EVNT_WIDTH default constant.
  - evt_id_t typedef (logic [EVNT_WIDTH-1:0]).
  - Localparam IDX_W = $clog2(NB_EVT).
- One sub-module, rr_arbiter_pointer: inputs req vector and last pointer; outputs gnt_valid and gnt_idx. Purely combinational wrap-around priority search, reusable by hw_dispatch-style blocks.
- Top holds pending, lost, output slot and pointer registers.

Test Plan:
- Single pulse evt_i[5] at cycle 10, evt_ready_i=1, ID_BASE=0 -> evt_valid_o=1 with evt_data_o=5 in cycle 12 only; busy_o returns 0 at cycle 13.
- evt_ready_i=0; pulses on sources 3, 7, 1 in the same cycle -> evt_valid_o=1, evt_data_o=1, held stable 20 cycles; after ready rises the IDs 1, 3, 7 go out on consecutive cycles.
- All 32 sources held pending, ready=1 toggling randomly -> every ID 0..31 sent exactly once, in ascending order from 0; the next round starts after 31 (fairness).
- Source 4 pending and blocked by ready=0, second pulse on 4 -> lost_o[4]=1 and only one ID 4 sent; lost_clr_i[4] pulse -> lost_o[4]=0 next cycle.
- Source 2 granted in cycle N with evt_i[2]=1 in cycle N -> ID 2 sent twice, lost_o[2] stays 0.
- Mask: evt_mask_i[6]=0 with a pulse on 6 -> nothing sent, no loss. rst_i asserted while valid=1 and ready=0 -> next cycle valid=0, pending=0, lost_o=0, and the first event after reset is searched from index 0.
